// File: rtl/doodle_pkg.sv
// Shared types and constants for the Doodle sprite read path.
package doodle_pkg;

    localparam int          SPRITE_DIM         = 16;
    localparam int          SPRITE_AW          = 8;
    localparam logic [23:0] DEFAULT_TRANSP_KEY = 24'hFF00FF;

    typedef logic [23:0] rgb_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } rdr_state_t;

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational sprite-box test: offset from the sprite origin, inside check,
// scaled row/col and optional horizontal flip. Shared by all sprite readers.
module sprite_hit_calc
    import doodle_pkg::*;
#(
    parameter int SCALE_LOG2 = 1
) (
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    input  logic [9:0] i_pos_x,
    input  logic [9:0] i_pos_y,
    input  logic       i_mirror,
    output logic       o_inside,
    output logic [3:0] o_row,
    output logic [3:0] o_col
);

    localparam int          SPAN   = SPRITE_DIM << SCALE_LOG2;
    localparam logic [10:0] SPAN_W = 11'(SPAN);

    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_in_x;
    logic        w_in_y;
    logic [3:0]  w_col;

    // Zero-extended subtraction: bit 10 set means the scan is left of / above the origin.
    assign w_dx = {1'b0, i_draw_x} - {1'b0, i_pos_x};
    assign w_dy = {1'b0, i_draw_y} - {1'b0, i_pos_y};

    assign w_in_x = ~w_dx[10] & (w_dx < SPAN_W);
    assign w_in_y = ~w_dy[10] & (w_dy < SPAN_W);

    assign w_col    = w_dx[SCALE_LOG2 +: 4];
    assign o_row    = w_dy[SCALE_LOG2 +: 4];
    assign o_col    = i_mirror ? ~w_col : w_col;
    assign o_inside = w_in_x & w_in_y;

endmodule

// File: rtl/doodle_sprite_reader.sv
// Doodle sprite RAM read front end: per-frame position latch, 3-cycle aligned pixel pipeline.
// Build option: DOODLE_MIRROR_EN flips the sprite horizontally when face_left=0.
module doodle_sprite_reader
    import doodle_pkg::*;
#(
    parameter int          SCALE_LOG2 = 1,
    parameter logic [23:0] TRANSP_KEY = DEFAULT_TRANSP_KEY
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  doodle_x,
    input  logic [9:0]  doodle_y,
    input  logic        face_left,
    output logic [7:0]  read_address5,
    input  logic [23:0] data_Out5,
    output logic [23:0] pixel_rgb,
    output logic        pixel_hit,
    output logic        pixel_valid
);

    // state      | meaning
    // WAIT_FRAME | no position latched since reset, hits suppressed
    // ACTIVE     | shadow position valid, hits allowed

    rdr_state_t r_state;
    rdr_state_t w_state_nxt;

    logic [9:0] r_sx;
    logic [9:0] r_sy;
    logic       r_face;
    logic       w_mirror;
    logic       w_box;
    logic [3:0] w_row;
    logic [3:0] w_col;
    logic       w_hit3;

    logic       r_hit1;
    logic       r_valid1;
    logic       r_hit2;
    logic       r_valid2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= WAIT_FRAME;
            r_sx    <= '0;
            r_sy    <= '0;
            r_face  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (frame_start) begin
                r_sx   <= doodle_x;
                r_sy   <= doodle_y;
                r_face <= face_left;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = ACTIVE;
        end
    end

`ifdef DOODLE_MIRROR_EN
    // Stored art faces left; flip it for right-facing frames.
    assign w_mirror = ~r_face;
`else
    // Facing has no visual effect without the mirror option.
    assign w_mirror = r_face & 1'b0;
`endif

    sprite_hit_calc #(
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_hit_calc (
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_pos_x  (r_sx),
        .i_pos_y  (r_sy),
        .i_mirror (w_mirror),
        .o_inside (w_box),
        .o_row    (w_row),
        .o_col    (w_col)
    );

    assign w_hit3 = r_hit2 & (data_Out5 != TRANSP_KEY);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address5 <= '0;
            r_hit1        <= 1'b0;
            r_valid1      <= 1'b0;
            r_hit2        <= 1'b0;
            r_valid2      <= 1'b0;
            pixel_rgb     <= '0;
            pixel_hit     <= 1'b0;
            pixel_valid   <= 1'b0;
        end else begin
            read_address5 <= {w_row, w_col};
            r_hit1        <= pix_valid & (r_state == ACTIVE) & w_box;
            r_valid1      <= pix_valid;
            r_hit2        <= r_hit1;
            r_valid2      <= r_valid1;
            pixel_hit     <= w_hit3;
            pixel_rgb     <= w_hit3 ? data_Out5 : '0;
            pixel_valid   <= r_valid2;
        end
    end

endmodule

// File: tb/tb_doodle_sprite_reader.sv
// Self-checking bench for doodle_sprite_reader against a per-pixel reference model.
module tb_doodle_sprite_reader;

    localparam int          SC   = 2;        // on-screen magnification for SCALE_LOG2=1
    localparam int          SPAN = 16 * SC;
    localparam logic [23:0] KEY  = 24'hFF00FF;
    localparam int          NV   = 4096;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, doodle_x = '0, doodle_y = '0;
    logic        face_left = 1'b0;
    logic [7:0]  read_address5;
    logic [23:0] data_Out5 = '0;
    logic [23:0] pixel_rgb;
    logic        pixel_hit;
    logic        pixel_valid;

    always #5 Clk = ~Clk;

    doodle_sprite_reader dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .doodle_x      (doodle_x),
        .doodle_y      (doodle_y),
        .face_left     (face_left),
        .read_address5 (read_address5),
        .data_Out5     (data_Out5),
        .pixel_rgb     (pixel_rgb),
        .pixel_hit     (pixel_hit),
        .pixel_valid   (pixel_valid)
    );

    logic [23:0] ram [256];
    always @(posedge Clk) data_Out5 <= ram[read_address5];

    // reference model state
    int          m_sx, m_sy;
    bit          m_face, m_active;
    bit          exp_valid [NV];
    bit          exp_hit   [NV];
    bit          exp_in    [NV];
    logic [23:0] exp_rgb   [NV];
    logic [7:0]  exp_addr  [NV];
    int          cyc = 0;
    bit          release_pending = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s vec=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    // One pixel clock: check outputs due this cycle, predict the new vector, drive it.
    task automatic step(input bit fs, input bit pv, input int x, input int y,
                        input int px, input int py, input bit fl);
        int xv, yv, dx, dy, col, row;
        bit in;
        @(posedge Clk); #1;
        if (cyc >= 1 && exp_in[cyc-1]) chk("addr", read_address5, exp_addr[cyc-1]);
        if (cyc >= 3) begin
            chk("valid", pixel_valid, exp_valid[cyc-3]);
            chk("hit",   pixel_hit,   exp_hit[cyc-3]);
            chk("rgb",   pixel_rgb,   exp_rgb[cyc-3]);
        end
        if (release_pending) begin
            Reset_n = 1'b1;
            release_pending = 1'b0;
        end
        xv = x & 1023;
        yv = y & 1023;
        exp_in[cyc] = 1'b0; exp_hit[cyc] = 1'b0; exp_valid[cyc] = 1'b0; exp_rgb[cyc] = '0;
        exp_addr[cyc] = '0;
        if (Reset_n) begin
            dx  = xv - m_sx;
            dy  = yv - m_sy;
            in  = pv && m_active && dx >= 0 && dx < SPAN && dy >= 0 && dy < SPAN;
            col = dx / SC;
            row = dy / SC;
`ifdef DOODLE_MIRROR_EN
            if (!m_face) col = 15 - col;
`endif
            exp_valid[cyc] = pv;
            if (in) begin
                exp_in[cyc]   = 1'b1;
                exp_addr[cyc] = 8'(row * 16 + col);
                if (ram[exp_addr[cyc]] != KEY) begin
                    exp_hit[cyc] = 1'b1;
                    exp_rgb[cyc] = ram[exp_addr[cyc]];
                end
            end
            if (fs) begin
                m_sx = px & 1023; m_sy = py & 1023; m_face = fl; m_active = 1'b1;
            end
        end
        frame_start = fs; pix_valid = pv;
        DrawX = 10'(xv); DrawY = 10'(yv);
        doodle_x = 10'(px); doodle_y = 10'(py); face_left = fl;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 0, 0, int'(doodle_x), int'(doodle_y), face_left);
    endtask

    task automatic reset_mid;
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_hit",   pixel_hit,     1'b0);
        chk("rst_valid", pixel_valid,   1'b0);
        chk("rst_rgb",   pixel_rgb,     24'h0);
        chk("rst_addr",  read_address5, 8'h00);
        for (int k = cyc - 3; k < cyc; k++) begin
            if (k >= 0) begin
                exp_valid[k] = 1'b0; exp_hit[k] = 1'b0; exp_rgb[k] = '0; exp_in[k] = 1'b0;
            end
        end
        m_sx = 0; m_sy = 0; m_face = 1'b0; m_active = 1'b0;
    endtask

    initial begin
        int px, py, x, y;
        bit fl;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 24'($urandom);
            if ($urandom_range(0, 7) == 0) ram[i] = KEY;
        end
        ram[8'h10] = 24'h123456;
        m_sx = 0; m_sy = 0; m_face = 1'b0; m_active = 1'b0;

        // held in reset for a few cycles, then released with no frame_start
        idle(3);
        release_pending = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, i[0], 100, 100, 90, 90, 1'b0);
        idle(3);

        // frame at (100,50), pixel (101,53) -> address 0x10
        step(1'b1, 1'b0, 0, 0, 100, 50, 1'b1);
        step(1'b0, 1'b1, 101, 53, 100, 50, 1'b1);
        idle(1);
        @(negedge Clk);
        chk("tp_addr10", read_address5, 8'h10);
        idle(2);
        @(negedge Clk);
        chk("tp_hit10", pixel_hit, 1'b1);
        chk("tp_rgb10", pixel_rgb, 24'h123456);
        idle(2);

        // same pixel with the transparent key stored
        ram[8'h10] = KEY;
        step(1'b0, 1'b1, 101, 53, 100, 50, 1'b1);
        idle(3);
        @(negedge Clk);
        chk("tp_key_hit", pixel_hit, 1'b0);
        chk("tp_key_rgb", pixel_rgb, 24'h0);
        ram[8'h10] = 24'h123456;

        // facing: origin pixel with face_left=0 then face_left=1
        step(1'b1, 1'b0, 0, 0, 100, 50, 1'b0);
        step(1'b0, 1'b1, 100, 50, 100, 50, 1'b0);
        idle(1);
        @(negedge Clk);
`ifdef DOODLE_MIRROR_EN
        chk("tp_mirror_r", read_address5, 8'h0F);
`else
        chk("tp_mirror_r", read_address5, 8'h00);
`endif
        step(1'b1, 1'b0, 0, 0, 100, 50, 1'b1);
        step(1'b0, 1'b1, 100, 50, 100, 50, 1'b1);
        idle(1);
        @(negedge Clk);
        chk("tp_mirror_l", read_address5, 8'h00);
        idle(2);

        // right-edge clipping, no wrap, mid-frame position change ignored
        step(1'b1, 1'b0, 0, 0, 630, 200, 1'b1);
        step(1'b0, 1'b1, 639, 205, 630, 200, 1'b1);
        step(1'b0, 1'b1, 0, 205, 630, 200, 1'b1);
        step(1'b0, 1'b1, 5, 205, 630, 200, 1'b1);
        step(1'b0, 1'b1, 639, 205, 10, 10, 1'b1);
        step(1'b0, 1'b1, 12, 12, 10, 10, 1'b1);
        step(1'b1, 1'b1, 12, 12, 10, 10, 1'b1);
        step(1'b0, 1'b1, 12, 12, 10, 10, 1'b1);
        idle(3);

        // reset in the middle of a hit run
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 10 + i, 14, 10, 10, 1'b1);
        reset_mid();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16 + i, 14, 10, 10, 1'b1);
        release_pending = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 20 + i, 14, 10, 10, 1'b1);
        step(1'b1, 1'b0, 0, 0, 10, 10, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 20 + i, 14, 10, 10, 1'b1);
        idle(3);

        // randomized frames around the sprite box
        for (int f = 0; f < 24; f++) begin
            px = $urandom_range(0, 639);
            py = $urandom_range(0, 479);
            fl = 1'($urandom_range(0, 1));
            step(1'b1, 1'b0, 0, 0, px, py, fl);
            for (int i = 0; i < 50; i++) begin
                x = px + int'($urandom_range(0, 44)) - 6;
                y = py + int'($urandom_range(0, 44)) - 6;
                if ($urandom_range(0, 9) == 0) begin
                    step(1'b0, 1'b1, x, y, $urandom_range(0, 639), $urandom_range(0, 479),
                         1'($urandom_range(0, 1)));
                end else if ($urandom_range(0, 29) == 0) begin
                    px = $urandom_range(0, 639);
                    py = $urandom_range(0, 479);
                    step(1'b1, 1'b1, x, y, px, py, fl);
                end else begin
                    step(1'b0, $urandom_range(0, 9) != 0, x, y, px, py, fl);
                end
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/doodle_sprite_reader.md
# doodle_sprite_reader

Read-side front end for the 16x16 Doodle sprite RAM. It latches the doodle's screen position and facing once per frame, then converts the VGA scan position into RAM read addresses. It absorbs the RAM's one-cycle synchronous read latency and returns an aligned pixel colour with a hit flag. It sits between the VGA controller/game logic and the sprite RAM, and feeds the colour mapper.

## Interface
Parameters:
- SCALE_LOG2, 1: on-screen magnification, 2^SCALE_LOG2 (default 32x32 on screen).
- TRANSP_KEY, 24'hFF00FF: sprite colour treated as transparent.

Ports:
- Clk, in, 1: pixel clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: single-cycle pulse at start of vertical blank.
- pix_valid, in, 1: DrawX/DrawY are within active video this cycle.
- DrawX, in, 10: current scan column.
- DrawY, in, 10: current scan row.
- doodle_x, in, 10: sprite top-left X from game logic.
- doodle_y, in, 10: sprite top-left Y from game logic.
- face_left, in, 1: 1 = left-facing, 0 = right-facing.
- read_address5, out, 8: sprite RAM read address, {row[3:0], col[3:0]}.
- data_Out5, in, 24: sprite RAM read data, valid one cycle after the address.
- pixel_rgb, out, 24: sprite colour for the pixel, or 0 when pixel_hit=0.
- pixel_hit, out, 1: sprite covers the pixel and it is not transparent.
- pixel_valid, out, 1: pixel_rgb/pixel_hit correspond to a pix_valid input three cycles earlier.

## Operation
- FSM has two states, WAIT_FRAME and ACTIVE.
  - Reset enters WAIT_FRAME. In WAIT_FRAME, pixel_hit is forced to 0 and the pipeline still runs.
  - frame_start in either state latches doodle_x, doodle_y and face_left into shadow registers and moves to ACTIVE.
  - No other transitions exist.
- Same-cycle game update and frame_start: the value present on the inputs that cycle is latched. Mid-frame changes to the inputs are ignored until the next frame_start.
- Stage 1 (registered):
  - dx = DrawX − sx and dy = DrawY − sy, computed 11-bit signed.
  - inside = pix_valid & state==ACTIVE & 0 ≤ dx,dy < (16<<SCALE_LOG2).
  - col = dx>>SCALE_LOG2 and row = dy>>SCALE_LOG2, low 4 bits.
  - read_address5 <= {row, col}; hit1 <= inside; valid1 <= pix_valid.
- Stage 2: the RAM returns data_Out5. hit2 and valid2 are delayed copies.
- Stage 3 (registered output):
  - pixel_hit <= hit2 & (data_Out5 != TRANSP_KEY).
  - pixel_rgb <= that hit ? data_Out5 : 0.
  - pixel_valid <= valid2.
- Edge clipping: no wrap. A sprite partly off the right or bottom edge is clipped. Negative dx/dy is a miss.
- read_address5 updates every cycle. When not inside, it holds the computed value, which is don't-care because hit suppresses the output.

## Timing
- Latency is exactly 3 Clk cycles from DrawX/DrawY/pix_valid to pixel_rgb/pixel_hit/pixel_valid. Throughput is one pixel per cycle, with no stalls.
- Reset values:
  - read_address5 = 0, pixel_rgb = 0, pixel_hit = 0, pixel_valid = 0.
  - All pipeline flags = 0; shadow position = 0; state = WAIT_FRAME.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). Hits stay suppressed until the next frame_start.
- A frame_start that arrives mid-scan takes effect for coordinates sampled on the following cycle.

## Configuration
- `DOODLE_MIRROR_EN` defined:
  - When the latched face_left = 0, col becomes 15 − col, giving a horizontal flip.
  - A single left-facing image serves both directions.
- Not defined: face_left is ignored (its shadow register may be optimised away) and the sprite is always drawn unflipped.

## Structure
- Shared package doodle_pkg holds:
  - SPRITE_DIM = 16 and SPRITE_AW = 8.
  - The default TRANSP_KEY, and typedef rgb_t (logic [23:0]).
  - typedef enum rdr_state_t {WAIT_FRAME, ACTIVE}.
- One sub-module, sprite_hit_calc: combinational dx/dy, inside test, row/col and mirror. It is reusable for the platform sprite readers.

## Test plan
- Reset release, no frame_start, scan (100,100) with doodle_x/y=90 → pixel_hit=0 throughout; pixel_valid follows pix_valid by 3 cycles.
- frame_start with doodle=(100,50), SCALE_LOG2=1, then DrawX=101, DrawY=53 → read_address5=8'h10 one cycle later. pixel_rgb equals RAM word 0x10 and pixel_hit=1, 3 cycles after the input.
- Same as above with RAM word 0x10 = FF00FF → pixel_hit=0, pixel_rgb=0.
- With `DOODLE_MIRROR_EN` and face_left=0 latched, DrawX=100, DrawY=50 → read_address5=8'h0F; with face_left=1 → 8'h00.
- doodle_x=630, scan DrawX=639 → hit (col 4). DrawX=0 → miss, no wrap. Change doodle_x mid-frame → no effect until the next frame_start.
- Assert Reset_n low during an active hit run → pixel_hit/pixel_valid drop to 0 in the same cycle. No hits appear after release until frame_start.
